// File: rtl/pmp_burst_ctrl.sv
// Captures a burst of decimated ADC samples into a FIFO and hands them to the PIC
// one byte per PMP request, with a synchronized request and a fixed data-setup time.
module pmp_burst_ctrl #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic        decim_clk,
  input  logic        rst,
  input  logic [7:0]  adc_data,
  input  logic        sample_en,
  input  logic        arm,
  input  logic [AW:0] burst_len,
  input  logic        pmp_dreq,
  output logic [7:0]  pmp_d,
  output logic        pmp_drdy,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [AW:0] level
);

  typedef enum logic [1:0] {B_IDLE, B_CAPTURE, B_DRAIN} burst_t;
  typedef enum logic [1:0] {S_WAIT, S_SETUP, S_READY} serve_t;

  localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYCLES - 1);

  burst_t        bst, bst_n;
  serve_t        sst, sst_n;
  logic          dreq_m, dreq_s;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   len_q, len_n, cap_cnt, cap_cnt_n, level_n;
  logic [3:0]    setup_cnt, setup_cnt_n;
  logic [7:0]    pmp_d_n;
  logic          drdy_n, busy_n, done_n, overrun_n;
  logic          wr_en, pop;

  // pmp_dreq comes from the PIC clock domain
  always_ff @(posedge decim_clk or posedge rst) begin
    if (rst) begin
      dreq_m <= 1'b0;
      dreq_s <= 1'b0;
    end else begin
      dreq_m <= pmp_dreq;
      dreq_s <= dreq_m;
    end
  end

  always_ff @(posedge decim_clk or posedge rst) begin
    if (rst) begin
      bst     <= B_IDLE;
      len_q   <= '0;
      cap_cnt <= '0;
      overrun <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      bst     <= bst_n;
      len_q   <= len_n;
      cap_cnt <= cap_cnt_n;
      overrun <= overrun_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    bst_n     = bst;
    len_n     = len_q;
    cap_cnt_n = cap_cnt;
    overrun_n = overrun;
    busy_n    = busy;
    done_n    = 1'b0;
    wr_en     = 1'b0;
    case (bst)
      B_IDLE: begin
        if (arm) begin
          len_n     = (burst_len == '0 || burst_len > DEPTH_L) ? DEPTH_L : burst_len;
          cap_cnt_n = '0;
          overrun_n = 1'b0;
          busy_n    = 1'b1;
          bst_n     = B_CAPTURE;
        end
      end
      B_CAPTURE: begin
        if (sample_en) begin
          cap_cnt_n = cap_cnt + 1'b1;
          if (level == DEPTH_L) overrun_n = 1'b1;
          else                  wr_en     = 1'b1;
          if (cap_cnt_n == len_q) bst_n = B_DRAIN;
        end
      end
      B_DRAIN: begin
        // serve side idle with nothing left means the PIC has taken every byte
        if (level == '0 && sst == S_WAIT) begin
          done_n = 1'b1;
          busy_n = 1'b0;
          bst_n  = B_IDLE;
        end
      end
      default: bst_n = B_IDLE;
    endcase
  end

  always_ff @(posedge decim_clk or posedge rst) begin
    if (rst) begin
      sst       <= S_WAIT;
      setup_cnt <= '0;
      pmp_d     <= '0;
      pmp_drdy  <= 1'b0;
    end else begin
      sst       <= sst_n;
      setup_cnt <= setup_cnt_n;
      pmp_d     <= pmp_d_n;
      pmp_drdy  <= drdy_n;
    end
  end

  always_comb begin
    sst_n       = sst;
    setup_cnt_n = setup_cnt;
    pmp_d_n     = pmp_d;
    drdy_n      = pmp_drdy;
    pop         = 1'b0;
    case (sst)
      S_WAIT: begin
        if (dreq_s && level != '0) begin
          sst_n       = S_SETUP;
          pmp_d_n     = mem[rd_ptr];
          setup_cnt_n = '0;
        end
      end
      S_SETUP: begin
        if (!dreq_s) begin
          sst_n   = S_WAIT;
          pmp_d_n = '0;
        end else if (setup_cnt == SETUP_LAST) begin
          sst_n  = S_READY;
          drdy_n = 1'b1;
        end else begin
          setup_cnt_n = setup_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (!dreq_s) begin
          sst_n   = S_WAIT;
          drdy_n  = 1'b0;
          pmp_d_n = '0;
          pop     = 1'b1;
        end
      end
      default: sst_n = S_WAIT;
    endcase
  end

  always_comb begin
    level_n = level;
    case ({wr_en, pop})
      2'b10:   level_n = level + 1'b1;
      2'b01:   level_n = level - 1'b1;
      default: level_n = level;
    endcase
  end

  always_ff @(posedge decim_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level_n;
    end
  end

  always_ff @(posedge decim_clk) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
  end

endmodule

// File: tb/tb_pmp_burst_ctrl.sv
// Bench for pmp_burst_ctrl: a queue-based burst/handshake model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_pmp_burst_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SETUP = 2;

  logic          decim_clk = 1'b0;
  logic          rst       = 1'b1;
  logic [7:0]    adc_data  = '0;
  logic          sample_en = 1'b0;
  logic          arm       = 1'b0;
  logic [AW:0]   burst_len = '0;
  logic          pmp_dreq  = 1'b0;
  logic [7:0]    pmp_d;
  logic          pmp_drdy, busy, done, overrun;
  logic [AW:0]   level;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  pmp_burst_ctrl #(.DEPTH(DEPTH), .AW(AW), .SETUP_CYCLES(SETUP)) dut (
    .decim_clk(decim_clk), .rst(rst), .adc_data(adc_data), .sample_en(sample_en),
    .arm(arm), .burst_len(burst_len), .pmp_dreq(pmp_dreq), .pmp_d(pmp_d),
    .pmp_drdy(pmp_drdy), .busy(busy), .done(done), .overrun(overrun), .level(level)
  );

  always #5 decim_clk = ~decim_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: FIFO as a queue, the request seen through a two-sample delay,
  // a transfer described by the number of edges since its byte was presented.
  logic [7:0] mq[$];
  logic [7:0] m_d = '0;
  logic [7:0] hd;
  logic       m_drdy = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_over = 1'b0;
  logic       m_serving = 1'b0;
  logic       h1 = 1'b0, h2 = 1'b0;
  logic       ds, do_pop, do_wr, comp;
  int         m_ticks = 0;
  int         m_rem = 0;
  int         blen;

  initial forever begin
    @(posedge decim_clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_d = '0; m_drdy = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_over = 1'b0;
      m_serving = 1'b0; h1 = 1'b0; h2 = 1'b0; m_ticks = 0; m_rem = 0;
    end else begin
      ds     = h2;
      comp   = m_busy && m_rem == 0 && mq.size() == 0 && !m_serving;
      do_pop = m_serving && m_ticks >= SETUP && !ds;
      do_wr  = 1'b0;
      if (m_serving) begin
        if (!ds) begin
          m_serving = 1'b0; m_d = '0; m_drdy = 1'b0;
        end else begin
          m_ticks++;
          m_drdy = (m_ticks >= SETUP);
        end
      end else if (ds && mq.size() > 0) begin
        m_serving = 1'b1; m_ticks = 0; m_d = mq[0];
      end
      m_done = 1'b0;
      if (!m_busy) begin
        if (arm) begin
          blen = int'(burst_len);
          if (blen == 0 || blen > DEPTH) blen = DEPTH;
          m_rem = blen; m_over = 1'b0; m_busy = 1'b1;
        end
      end else if (comp) begin
        m_done = 1'b1; m_busy = 1'b0;
      end else if (m_rem > 0 && sample_en) begin
        m_rem--;
        if (mq.size() < DEPTH) do_wr = 1'b1;
        else                   m_over = 1'b1;
      end
      if (do_pop) hd = mq.pop_front();
      if (do_wr) mq.push_back(adc_data);
      h2 = h1;
      h1 = pmp_dreq;
    end
  end

  always @(negedge decim_clk) begin
    if (!rst) begin
      chk("pmp_d",    32'(pmp_d),    32'(m_d));
      chk("pmp_drdy", 32'(pmp_drdy), 32'(m_drdy));
      chk("busy",     32'(busy),     32'(m_busy));
      chk("done",     32'(done),     32'(m_done));
      chk("overrun",  32'(overrun),  32'(m_over));
      chk("level",    32'(level),    32'(mq.size()));
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge decim_clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic sample(input logic [7:0] d);
    adc_data = d; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_arm(input int l);
    arm = 1'b1; burst_len = (AW+1)'(l);
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_drdy(input logic v, input int budget, output int n);
    n = 0;
    while (pmp_drdy !== v && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake(output logic [7:0] d, output int nr, output int nf);
    pmp_dreq = 1'b1;
    wait_drdy(1'b1, 40, nr);
    d = pmp_d;
    pmp_dreq = 1'b0;
    wait_drdy(1'b0, 40, nf);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_d"},    32'(pmp_d),    32'd0);
    chk({tag, "_drdy"}, 32'(pmp_drdy), 32'd0);
    chk({tag, "_busy"}, 32'(busy),     32'd0);
    chk({tag, "_done"}, 32'(done),     32'd0);
    chk({tag, "_ovr"},  32'(overrun),  32'd0);
    chk({tag, "_lvl"},  32'(level),    32'd0);
  endtask

  logic [7:0] d;
  logic [7:0] exp_b [20];
  int nr, nf, hold;
  logic [7:0] t1 [4];

  initial begin
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;
    idle(2);
    check_zero("reset");
    rst = 1'b0;
    tick();

    // basic 4-sample burst and four full handshakes
    done_cnt = 0;
    do_arm(4);
    for (int i = 0; i < 4; i++) sample(t1[i]);
    chk("t1_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      handshake(d, nr, nf);
      chk("t1_data", 32'(d), 32'(t1[i]));
      chk("t1_rise", 32'(nr), 32'(3 + SETUP));
      chk("t1_fall", 32'(nf), 32'd3);
    end
    idle(3);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ovr", 32'(overrun), 32'd0);

    // length 0 and length 16 both clamp/capture exactly DEPTH samples
    for (int b = 0; b < 2; b++) begin
      do_arm(b == 0 ? 0 : 16);
      for (int i = 0; i < 20; i++) begin
        exp_b[i] = 8'($urandom);
        sample(exp_b[i]);
      end
      chk("t2_level", 32'(level), 32'd16);
      chk("t2_ovr", 32'(overrun), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 16; i++) begin
        handshake(d, nr, nf);
        chk("t2_data", 32'(d), 32'(exp_b[i]));
      end
      idle(3);
      chk("t2_idle", 32'(busy), 32'd0);
    end

    // request held over an empty FIFO, then write and pop on the same edge
    do_arm(3);
    pmp_dreq = 1'b1;
    idle(6);
    chk("t4_d_empty", 32'(pmp_d), 32'd0);
    chk("t4_drdy_empty", 32'(pmp_drdy), 32'd0);
    sample(8'h5A);
    wait_drdy(1'b1, 40, nr);
    chk("t4_rise", 32'(nr), 32'(1 + SETUP));
    chk("t4_data", 32'(pmp_d), 32'h5A);
    pmp_dreq = 1'b0;
    idle(2);
    chk("t4_lvl_pre", 32'(level), 32'd1);
    sample(8'hA5);
    chk("t4_lvl_post", 32'(level), 32'd1);
    chk("t4_drdy_post", 32'(pmp_drdy), 32'd0);
    sample(8'hC3);
    handshake(d, nr, nf);
    chk("t4_data2", 32'(d), 32'hA5);
    handshake(d, nr, nf);
    chk("t4_data3", 32'(d), 32'hC3);
    idle(3);

    // request dropped during setup
    do_arm(2);
    sample(8'h77);
    sample(8'h88);
    pmp_dreq = 1'b1;
    tick();
    pmp_dreq = 1'b0;
    idle(2);
    chk("t5_d_setup", 32'(pmp_d), 32'h77);
    chk("t5_drdy_setup", 32'(pmp_drdy), 32'd0);
    tick();
    chk("t5_d_abort", 32'(pmp_d), 32'd0);
    chk("t5_drdy_abort", 32'(pmp_drdy), 32'd0);
    chk("t5_lvl_abort", 32'(level), 32'd2);
    handshake(d, nr, nf);
    chk("t5_same_byte", 32'(d), 32'h77);
    chk("t5_rise", 32'(nr), 32'(3 + SETUP));

    // asynchronous reset while presenting, then re-arm
    pmp_dreq = 1'b1;
    wait_drdy(1'b1, 40, nr);
    chk("t6_drdy_up", 32'(pmp_drdy), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero("t6_rst");
    pmp_dreq = 1'b0;
    @(posedge decim_clk);
    #1 rst = 1'b0;
    do_arm(2);
    chk("t6_busy", 32'(busy), 32'd1);
    do_arm(5);
    sample(8'h01); sample(8'h02); sample(8'h03);
    chk("t6_level", 32'(level), 32'd2);
    handshake(d, nr, nf);
    chk("t6_data", 32'(d), 32'h01);
    handshake(d, nr, nf);
    idle(3);

    // randomized soak, compared cycle by cycle against the model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      arm       = ($urandom_range(0, 19) == 0);
      burst_len = (AW+1)'($urandom_range(0, 31));
      sample_en = ($urandom_range(0, 2) == 0);
      adc_data  = 8'($urandom);
      if (hold == 0) begin
        pmp_dreq = ~pmp_dreq;
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      if (c == 2000) begin
        #2 rst = 1'b1;
        #1 chk("soak_rst_lvl", 32'(level), 32'd0);
        @(posedge decim_clk);
        #1 rst = 1'b0;
      end
      tick();
    end
    arm = 1'b0; sample_en = 1'b0; pmp_dreq = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
